// File: rtl/test_harness_ctrl.sv
// Run controller for the pipelined CPU test harness.
// Sequences the core reset, counts RUN cycles and retired instructions, decodes
// mailbox/console writes on the core data-memory write port and ends the run as
// PASS, FAIL or TIMEOUT. All outputs are registered.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   mem_we_i       core data-memory write strobe
//   mem_addr_i     core data-memory write address (byte)
//   mem_wdata_i    core data-memory write data
//   retire_i       one pulse per retired instruction
//   core_rst_o     reset to the CPU core (high in HOLD and in terminal states)
//   running_o      high in RUN
//   done_o         high in any terminal state
//   pass_o         high in PASS
//   fail_o         high in FAIL
//   timeout_o      high in TIMEOUT
//   exit_code_o    mailbox value, or all-ones on timeout
//   cycle_count_o  RUN cycles elapsed (saturating)
//   retire_count_o instructions retired during RUN (saturating)
//   con_valid_o    console byte strobe, one cycle per console write
//   con_data_o     console byte
module test_harness_ctrl #(
  parameter int unsigned             ADDR_WIDTH   = 32,
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             CNT_WIDTH    = 32,
  parameter int unsigned             RST_CYCLES   = 2,
  parameter int unsigned             TIMEOUT      = 1000,
  parameter logic [ADDR_WIDTH-1:0]   TOHOST_ADDR  = 'h0000_0FF0,
  parameter logic [ADDR_WIDTH-1:0]   CONSOLE_ADDR = 'h0000_0FF4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  input  logic                  retire_i,
  output logic                  core_rst_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] exit_code_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic [CNT_WIDTH-1:0]  retire_count_o,
  output logic                  con_valid_o,
  output logic [7:0]            con_data_o
);

  localparam int unsigned HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {StHold, StRun, StPass, StFail, StTimeout} state_e;

  state_e                state_q, state_d;
  logic [HoldW-1:0]      hold_q, hold_d;
  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d, ret_q, ret_d, cyc_inc, ret_inc;
  logic [DATA_WIDTH-1:0] exit_q, exit_d;
  logic                  con_valid_q, con_valid_d;
  logic [7:0]            con_data_q, con_data_d;
  logic                  core_rst_q, core_rst_d, running_q, running_d;
  logic                  done_q, done_d, pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic                  tohost_wr, console_wr, timeout_hit;

  assign tohost_wr  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
  assign console_wr = mem_we_i && (mem_addr_i == CONSOLE_ADDR);

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_WIDTH'(1);
  assign ret_inc = (ret_q == '1) ? ret_q : ret_q + CNT_WIDTH'(1);
  // Fires on the edge where cycle_count becomes TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (cyc_inc == CNT_WIDTH'(TIMEOUT));

  // State register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StHold;
      hold_q      <= '0;
      cyc_q       <= '0;
      ret_q       <= '0;
      exit_q      <= '0;
      con_valid_q <= 1'b0;
      con_data_q  <= '0;
      core_rst_q  <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      exit_q      <= exit_d;
      con_valid_q <= con_valid_d;
      con_data_q  <= con_data_d;
      core_rst_q  <= core_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      to_q        <= to_d;
    end
  end

  // Next-state and datapath. Only RUN moves counters; terminal states freeze everything.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cyc_d       = cyc_q;
    ret_d       = ret_q;
    exit_d      = exit_q;
    con_valid_d = 1'b0;
    con_data_d  = con_data_q;
    unique case (state_q)
      StHold: begin
        hold_d = hold_q + HoldW'(1);
        if (hold_q == HoldW'(RST_CYCLES - 1)) state_d = StRun;
      end
      StRun: begin
        cyc_d = cyc_inc;
        if (retire_i) ret_d = ret_inc;
        // Mailbox write takes priority over a timeout on the same edge.
        if (tohost_wr) begin
          state_d = (mem_wdata_i == DATA_WIDTH'(1)) ? StPass : StFail;
          exit_d  = mem_wdata_i;
        end else if (timeout_hit) begin
          state_d = StTimeout;
          exit_d  = '1;
        end else if (console_wr) begin
          // No strobe leaks into a terminal state.
          con_valid_d = 1'b1;
          con_data_d  = mem_wdata_i[7:0];
        end
      end
      default: ;
    endcase
  end

  // Status flags follow the next state so they line up with it after the edge.
  always_comb begin
    core_rst_d = (state_d != StRun);
    running_d  = (state_d == StRun);
    pass_d     = (state_d == StPass);
    fail_d     = (state_d == StFail);
    to_d       = (state_d == StTimeout);
    done_d     = pass_d || fail_d || to_d;
  end

  assign core_rst_o     = core_rst_q;
  assign running_o      = running_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = to_q;
  assign exit_code_o    = exit_q;
  assign cycle_count_o  = cyc_q;
  assign retire_count_o = ret_q;
  assign con_valid_o    = con_valid_q;
  assign con_data_o     = con_data_q;

endmodule

// File: tb/tb_test_harness_ctrl.sv
module tb_test_harness_ctrl;

  localparam int unsigned TMO     = 20;
  localparam logic [31:0] TOHOST  = 32'h0000_0FF0;
  localparam logic [31:0] CONSOLE = 32'h0000_0FF4;
  localparam logic [31:0] OTHER   = 32'h0000_0FF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        retire = 1'b0;
  logic        core_rst, running, done, pass, fail, timeout, con_valid;
  logic [31:0] exit_code, cycle_count, retire_count;
  logic [7:0]  con_data;

  int checks = 0;
  int passed = 0;

  // Run-level reference model: 0 run, 1 pass, 2 fail, 3 timeout.
  int          m_st;
  int unsigned m_cyc, m_ret;
  logic [31:0] m_exit;
  logic        m_cv;
  logic [7:0]  m_cd;

  test_harness_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .retire_i(retire), .core_rst_o(core_rst),
    .running_o(running), .done_o(done), .pass_o(pass), .fail_o(fail),
    .timeout_o(timeout), .exit_code_o(exit_code), .cycle_count_o(cycle_count),
    .retire_count_o(retire_count), .con_valid_o(con_valid), .con_data_o(con_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running=%0b required done", running);
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs at a negedge, return at the next negedge with inputs idle.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic ret);
    mem_we = we; mem_addr = addr; mem_wdata = wd; retire = ret;
    @(negedge clk);
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; retire = 1'b0;
  endtask

  task automatic enter_run();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    m_st = 0; m_cyc = 0; m_ret = 0; m_exit = '0; m_cv = 1'b0; m_cd = '0;
  endtask

  task automatic model_step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic ret);
    m_cv = 1'b0;
    if (m_st == 0) begin
      m_cyc++;
      if (ret) m_ret++;
      if (we && addr == TOHOST) begin
        m_st = (wd == 32'd1) ? 1 : 2;
        m_exit = wd;
      end else if (m_cyc == TMO) begin
        m_st = 3;
        m_exit = 32'hFFFF_FFFF;
      end else if (we && addr == CONSOLE) begin
        m_cv = 1'b1;
        m_cd = wd[7:0];
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({core_rst, running, done, con_valid} !== 4'b1000 || cycle_count !== 0
        || retire_count !== 0 || exit_code !== 0) begin
      $display("FAIL reset_state: got core_rst=%0b running=%0b done=%0b cyc=%0d exit=%h",
               core_rst, running, done, cycle_count, exit_code);
    end else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || running !== 1'b0)
      $display("FAIL hold_edge1: got core_rst=%0b running=%0b required 1 0", core_rst, running);
    else passed++;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || running !== 1'b1 || cycle_count !== 0)
      $display("FAIL hold_edge2: got core_rst=%0b running=%0b cyc=%0d required 0 1 0",
               core_rst, running, cycle_count);
    else passed++;
  endtask

  task automatic test_pass();
    logic [4:0] pat = 5'b11011;
    enter_run();
    for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, pat[i]);
    drive(1'b1, TOHOST, 32'd1, 1'b0);
    checks++;
    if ({pass, done, core_rst, fail} !== 4'b1110 || exit_code !== 1 || cycle_count !== 6
        || retire_count !== 4)
      $display("FAIL pass_run: got pass=%0b done=%0b core_rst=%0b exit=%h cyc=%0d ret=%0d",
               pass, done, core_rst, exit_code, cycle_count, retire_count);
    else passed++;
  endtask

  task automatic test_fail_sticky();
    enter_run();
    drive(1'b1, TOHOST, 32'h2A, 1'b0);
    checks++;
    if (fail !== 1'b1 || exit_code !== 32'h2A || running !== 1'b0)
      $display("FAIL fail_run: got fail=%0b exit=%h running=%0b required 1 0000002a 0",
               fail, exit_code, running);
    else passed++;
    drive(1'b1, TOHOST, 32'd1, 1'b1);
    drive(1'b1, CONSOLE, 32'h41, 1'b1);
    checks++;
    if (fail !== 1'b1 || pass !== 1'b0 || exit_code !== 32'h2A || cycle_count !== 1
        || retire_count !== 0 || con_valid !== 1'b0)
      $display("FAIL fail_sticky: got fail=%0b pass=%0b exit=%h cyc=%0d ret=%0d cv=%0b",
               fail, pass, exit_code, cycle_count, retire_count, con_valid);
    else passed++;
  endtask

  task automatic test_timeout();
    enter_run();
    for (int i = 0; i < TMO - 1; i++) drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (timeout !== 1'b0 || running !== 1'b1 || cycle_count !== TMO - 1)
      $display("FAIL timeout_early: got timeout=%0b cyc=%0d required 0 %0d",
               timeout, cycle_count, TMO - 1);
    else passed++;
    drive(1'b0, '0, '0, 1'b0);
    checks++;
    if (timeout !== 1'b1 || done !== 1'b1 || cycle_count !== TMO || exit_code !== 32'hFFFF_FFFF)
      $display("FAIL timeout_hit: got timeout=%0b cyc=%0d exit=%h required 1 %0d ffffffff",
               timeout, cycle_count, exit_code, TMO);
    else passed++;
    enter_run();
    for (int i = 0; i < TMO - 1; i++) drive(1'b0, '0, '0, 1'b0);
    drive(1'b1, TOHOST, 32'd1, 1'b1);
    checks++;
    if (pass !== 1'b1 || timeout !== 1'b0 || cycle_count !== TMO || retire_count !== 1)
      $display("FAIL mailbox_beats_timeout: got pass=%0b timeout=%0b cyc=%0d ret=%0d",
               pass, timeout, cycle_count, retire_count);
    else passed++;
  endtask

  task automatic test_back_to_back_console();
    enter_run();
    drive(1'b1, CONSOLE, 32'h148, 1'b0);
    checks++;
    if (con_valid !== 1'b1 || con_data !== 8'h48)
      $display("FAIL console_first: got cv=%0b data=%h required 1 48", con_valid, con_data);
    else passed++;
    drive(1'b1, CONSOLE, 32'h69, 1'b0);
    checks++;
    if (con_valid !== 1'b1 || con_data !== 8'h69)
      $display("FAIL console_second: got cv=%0b data=%h required 1 69", con_valid, con_data);
    else passed++;
    drive(1'b1, OTHER, 32'd1, 1'b0);
    checks++;
    if (con_valid !== 1'b0 || running !== 1'b1 || done !== 1'b0 || exit_code !== 0
        || cycle_count !== 3)
      $display("FAIL other_addr: got cv=%0b running=%0b done=%0b exit=%h cyc=%0d",
               con_valid, running, done, exit_code, cycle_count);
    else passed++;
  endtask

  task automatic test_async_reset();
    enter_run();
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1);
    checks++;
    if (cycle_count !== 3 || retire_count !== 3)
      $display("FAIL pre_reset_counts: got cyc=%0d ret=%0d required 3 3",
               cycle_count, retire_count);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (core_rst !== 1'b1 || running !== 1'b0 || cycle_count !== 0 || retire_count !== 0)
      $display("FAIL async_reset: got core_rst=%0b running=%0b cyc=%0d ret=%0d",
               core_rst, running, cycle_count, retire_count);
    else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b1 || running !== 1'b0)
      $display("FAIL rehold_edge1: got core_rst=%0b running=%0b required 1 0", core_rst, running);
    else passed++;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || running !== 1'b1 || cycle_count !== 0)
      $display("FAIL rehold_edge2: got core_rst=%0b running=%0b cyc=%0d required 0 1 0",
               core_rst, running, cycle_count);
    else passed++;
  endtask

  task automatic test_random();
    logic        we, ret;
    logic [31:0] addr, wd;
    logic [47:0] got, exp;
    for (int run = 0; run < 6; run++) begin
      enter_run();
      for (int c = 0; c < 26; c++) begin
        ret = 1'($urandom_range(0, 1));
        we  = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 11))
          0:          addr = TOHOST;
          1, 2, 3, 4: addr = CONSOLE;
          5, 6:       addr = OTHER;
          default:    addr = $urandom;
        endcase
        case ($urandom_range(0, 2))
          0:       wd = 32'd1;
          1:       wd = 32'd0;
          default: wd = $urandom;
        endcase
        drive(we, addr, wd, ret);
        model_step(we, addr, wd, ret);
        got = {core_rst, running, done, pass, fail, timeout, con_valid, con_data,
               cycle_count[19:0], retire_count[19:0]};
        exp = {m_st != 0, m_st == 0, m_st != 0, m_st == 1, m_st == 2, m_st == 3, m_cv, m_cd,
               m_cyc[19:0], m_ret[19:0]};
        checks++;
        if (got !== exp || exit_code !== m_exit)
          $display("FAIL random run%0d cyc%0d: got %h exit=%h required %h exit=%h",
                   run, c, got, exit_code, exp, m_exit);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_sticky();
    test_timeout();
    test_back_to_back_console();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/test_harness_ctrl.md
Name:
test_harness_ctrl

Overview:
Synthesizable, self-checking run controller for the pipelined CPU. It sequences core reset and counts cycles and retired instructions. It decodes memory-mapped mailbox and console writes on the core data-memory write port, and terminates the run as PASS, FAIL or TIMEOUT. It replaces fixed-delay simulation benches with a parametrised, per-program pass/fail result usable in simulation and on FPGA.

Parameters:
ADDR_WIDTH, 32, width of mem_addr
DATA_WIDTH, 32, width of mem_wdata and exit_code
CNT_WIDTH, 32, width of cycle_count and retire_count
RST_CYCLES, 2, clocks core_rst is held after rst deasserts (must be >= 1)
TIMEOUT, 1000, maximum RUN cycles before TIMEOUT; 0 disables the timeout
TOHOST_ADDR, 32'h0000_0FF0, byte address of the pass/fail mailbox
CONSOLE_ADDR, 32'h0000_0FF4, byte address of the character console

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
mem_we  in  1  core data-memory write strobe
mem_addr  in  ADDR_WIDTH  core data-memory write address
mem_wdata  in  DATA_WIDTH  core data-memory write data
retire  in  1  single-cycle pulse per retired instruction
core_rst  out  1  reset to the CPU core
running  out  1  high in RUN
done  out  1  high in any terminal state
pass  out  1  high in PASS
fail  out  1  high in FAIL
timeout  out  1  high in TIMEOUT
exit_code  out  DATA_WIDTH  mailbox value or termination code
cycle_count  out  CNT_WIDTH  RUN cycles elapsed
retire_count  out  CNT_WIDTH  instructions retired during RUN
con_valid  out  1  console byte strobe
con_data  out  8  console byte

Behaviour:
- One clock domain (clk). rst is asynchronous, active-high. All outputs are registered.
- Reset values: state=HOLD, core_rst=1, all other outputs 0, hold counter 0.
- States:
  - HOLD: core_rst=1. Hold counter increments each edge. At the edge where it equals RST_CYCLES-1, go to RUN. core_rst is therefore high for exactly RST_CYCLES edges after rst falls. mem_*/retire are ignored.
  - RUN: core_rst=0, running=1.
    - cycle_count +1 on every RUN edge, including the terminating edge.
    - retire_count +1 on each edge with retire=1.
    - Both counters saturate at all-ones and never wrap.
  - Mailbox: mem_we=1 and mem_addr==TOHOST_ADDR.
    - wdata==1 -> PASS, exit_code=1.
    - Any other wdata (including 0) -> FAIL, exit_code=wdata.
  - Timeout: TIMEOUT!=0 and the edge where cycle_count becomes TIMEOUT -> TIMEOUT, exit_code=all-ones.
  - Same-edge conflict: a mailbox write beats timeout.
  - Console: mem_we=1 and mem_addr==CONSOLE_ADDR -> con_valid=1 for exactly the following cycle, con_data=wdata[7:0]. Back-to-back writes give back-to-back strobes. Console is active in RUN only.
  - Address compare is full-width equality. Other addresses have no effect.
- PASS/FAIL/TIMEOUT are terminal and sticky until rst:
  - done=1, running=0, core_rst=1 (freezes the core).
  - Counters and exit_code are frozen.
  - Further mailbox, console and retire inputs are ignored; con_valid=0.
- A retire on the terminating edge is counted.
- rst asserted mid-run: asynchronously returns to HOLD with all counters, flags and exit_code cleared before the next edge.

Test Plan:
1. RST_CYCLES=2. Hold rst for 3 edges, release -> core_rst stays 1 for exactly 2 further edges, then core_rst=0, running=1, cycle_count=0.
2. In RUN: retire on 4 of the first 5 cycles, then write 1 to 0xFF0 on the 6th cycle (retire=0) -> pass=1, done=1, exit_code=1, cycle_count=6, retire_count=4, core_rst=1.
3. Write 0x2A to 0xFF0 -> fail=1, exit_code=0x2A. A later write of 1 to 0xFF0 leaves fail=1, pass=0, exit_code unchanged.
4. TIMEOUT=20, no mailbox writes -> timeout=1, cycle_count=20, exit_code=0xFFFFFFFF. Rerun with a write of 1 on the 20th cycle -> pass=1, timeout=0.
5. Write 0x48 then 0x69 to 0xFF4 on consecutive cycles -> con_valid high two consecutive cycles with con_data 0x48 then 0x69. A write to 0xFF8 produces no strobe and no state change.
6. Assert rst asynchronously mid-RUN (between edges) -> before the next edge: core_rst=1, running=0, counters 0. After release, the HOLD sequence repeats exactly as in scenario 1.
